// File: rtl/load_mem_ctrl.sv
// MEM-stage load controller: pre-checks alignment, issues a doubleword-aligned
// read over a valid/ready channel and registers the raw response for the formatter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for i_start; alignment and func3 legality decided here
// S_REQ   | o_mem_req high, waiting for i_mem_ready
// S_WAIT  | request accepted, waiting for i_mem_rvalid or timeout
// S_DRAIN | flushed after handshake, swallowing the single outstanding response
// S_DONE  | o_done pulse with o_misaligned / o_access_fault valid
module load_mem_ctrl #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_func_3,
  input  logic                  i_flush,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [2:0]            o_addr_offset,
  output logic [2:0]            o_func_3,
  output logic                  o_done,
  output logic                  o_misaligned,
  output logic                  o_access_fault,
  output logic                  o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             start_illegal;
  logic             start_misaligned;

  // func3[1:0] encodes the access size for both signed and unsigned loads
  always_comb begin
    start_illegal    = (i_func_3 == 3'b111);
    start_misaligned = 1'b0;
    case (i_func_3[1:0])
      2'b01:   start_misaligned = i_addr[0];
      2'b10:   start_misaligned = |i_addr[1:0];
      2'b11:   start_misaligned = |i_addr[2:0];
      default: start_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      o_mem_req      <= 1'b0;
      o_mem_addr     <= '0;
      o_data         <= '0;
      o_addr_offset  <= 3'b000;
      o_func_3       <= 3'b000;
      o_done         <= 1'b0;
      o_misaligned   <= 1'b0;
      o_access_fault <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_addr_offset <= i_addr[2:0];
            o_func_3      <= i_func_3;
            o_mem_addr    <= {i_addr[ADDR_WIDTH-1:3], 3'b000};
            if (start_illegal) begin
              state          <= S_DONE;
              o_done         <= 1'b1;
              o_access_fault <= 1'b1;
            end else if (start_misaligned) begin
              state        <= S_DONE;
              o_done       <= 1'b1;
              o_misaligned <= 1'b1;
            end else begin
              state     <= S_REQ;
              o_mem_req <= 1'b1;
              o_busy    <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (i_mem_ready) begin
            o_mem_req <= 1'b0;
            wait_cnt  <= '0;
            state     <= i_flush ? S_DRAIN : S_WAIT;
          end else if (i_flush) begin
            // memory side tolerates a withdrawn request
            o_mem_req <= 1'b0;
            o_busy    <= 1'b0;
            state     <= S_IDLE;
          end
        end

        S_WAIT: begin
          if (i_mem_rvalid) begin
            o_busy <= 1'b0;
            if (i_flush) begin
              state <= S_IDLE;
            end else begin
              o_data <= i_mem_rdata;
              o_done <= 1'b1;
              state  <= S_DONE;
            end
          end else if (i_flush) begin
            state <= S_DRAIN;
          end else if (wait_cnt == CNT_LAST) begin
            o_busy         <= 1'b0;
            o_done         <= 1'b1;
            o_access_fault <= 1'b1;
            state          <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          if (i_mem_rvalid) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end

        S_DONE: begin
          o_done         <= 1'b0;
          o_misaligned   <= 1'b0;
          o_access_fault <= 1'b0;
          state          <= S_IDLE;
        end

        default: begin
          o_mem_req      <= 1'b0;
          o_done         <= 1'b0;
          o_misaligned   <= 1'b0;
          o_access_fault <= 1'b0;
          o_busy         <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_mem_ctrl.sv
// Bench for load_mem_ctrl: directed memory-side stimulus with a result
// scoreboard popped on every o_done pulse.
module tb_load_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] addr;
  logic [2:0]  func_3;
  logic        flush;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [63:0] data;
  logic [2:0]  addr_offset;
  logic [2:0]  func_3_q;
  logic        done;
  logic        misaligned;
  logic        access_fault;
  logic        busy;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  off;
    logic [2:0]  f3;
    logic        mis;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] last_data;

  load_mem_ctrl #(
    .ADDR_WIDTH    (64),
    .DATA_WIDTH    (64),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk         (clk),
    .i_arstn       (rst_n),
    .i_start       (start),
    .i_addr        (addr),
    .i_func_3      (func_3),
    .i_flush       (flush),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ready   (mem_ready),
    .i_mem_rvalid  (mem_rvalid),
    .i_mem_rdata   (mem_rdata),
    .o_data        (data),
    .o_addr_offset (addr_offset),
    .o_func_3      (func_3_q),
    .o_done        (done),
    .o_misaligned  (misaligned),
    .o_access_fault(access_fault),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [2:0] off, input logic [2:0] f3,
                      input logic mis, input logic fault);
    exp_t e;
    e.data = d; e.off = off; e.f3 = f3; e.mis = mis; e.fault = fault;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [63:0] a, input logic [2:0] f3);
    start  = 1'b1;
    addr   = a;
    func_3 = f3;
    tick();
    start  = 1'b0;
  endtask

  task automatic respond(input logic [63:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic handshake();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  // Scoreboard consumer: every o_done must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_data", data, e.data);
        chk("sb_offset", {61'd0, addr_offset}, {61'd0, e.off});
        chk("sb_func3", {61'd0, func_3_q}, {61'd0, e.f3});
        chk("sb_misaligned", {63'd0, misaligned}, {63'd0, e.mis});
        chk("sb_fault", {63'd0, access_fault}, {63'd0, e.fault});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; addr = '0; func_3 = '0; flush = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    last_data = '0;
    tick(); tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_data", data, 64'd0);
    rst_n = 1'b1;
    tick();

    // LD 0x1000, minimum latency
    last_data = 64'hDEADBEEF_CAFEF00D;
    push(last_data, 3'd0, 3'b011, 1'b0, 1'b0);
    issue(64'h1000, 3'b011);
    chk("ld_req", {63'd0, mem_req}, 64'd1);
    chk("ld_mem_addr", mem_addr, 64'h1000);
    chk("ld_busy", {63'd0, busy}, 64'd1);
    handshake();
    chk("ld_req_drop", {63'd0, mem_req}, 64'd0);
    chk("ld_done_early", {63'd0, done}, 64'd0);
    respond(64'hDEADBEEF_CAFEF00D);
    chk("ld_done_cyc3", {63'd0, done}, 64'd1);
    chk("ld_busy_done", {63'd0, busy}, 64'd0);
    tick();
    chk("ld_done_one", {63'd0, done}, 64'd0);

    // LW misaligned
    push(last_data, 3'd6, 3'b010, 1'b1, 1'b0);
    issue(64'h2006, 3'b010);
    chk("lw_mis_req", {63'd0, mem_req}, 64'd0);
    chk("lw_mis_done", {63'd0, done}, 64'd1);
    tick();
    chk("lw_mis_clear", {63'd0, misaligned}, 64'd0);

    // LB 0x2007, ready stalled 3 cycles, response 5 cycles after handshake
    last_data = 64'h01234567_89ABCDEF;
    push(last_data, 3'd7, 3'b000, 1'b0, 1'b0);
    issue(64'h2007, 3'b000);
    for (int i = 0; i < 3; i++) begin
      chk("lb_req_held", {63'd0, mem_req}, 64'd1);
      chk("lb_mem_addr", mem_addr, 64'h2000);
      chk("lb_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    chk("lb_mem_addr_hs", mem_addr, 64'h2000);
    handshake();
    for (int i = 0; i < 4; i++) begin
      chk("lb_busy_wait", {63'd0, busy}, 64'd1);
      tick();
    end
    respond(last_data);
    chk("lb_done", {63'd0, done}, 64'd1);
    tick();

    // flush in WAIT, response arrives in DRAIN
    issue(64'h3000, 3'b011);
    handshake();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    respond(64'hBAD0BAD0_BAD0BAD0);
    chk("drain_exit_busy", {63'd0, busy}, 64'd0);
    chk("drain_data_kept", data, last_data);
    tick();

    // next load serviced normally
    last_data = 64'h11112222_33334444;
    push(last_data, 3'd2, 3'b001, 1'b0, 1'b0);
    issue(64'h4002, 3'b001);
    handshake();
    respond(last_data);
    chk("post_flush_done", {63'd0, done}, 64'd1);
    tick();

    // timeout after 8 WAIT cycles, then a late response ignored
    push(last_data, 3'd0, 3'b011, 1'b0, 1'b1);
    issue(64'h5000, 3'b011);
    handshake();
    for (int i = 0; i < 7; i++) begin
      chk("to_no_done", {63'd0, done}, 64'd0);
      tick();
    end
    chk("to_still_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("to_done", {63'd0, done}, 64'd1);
    tick();
    respond(64'hFFFF0000_FFFF0000);
    chk("late_rsp_data", data, last_data);
    tick();

    // illegal func3
    push(last_data, 3'd3, 3'b111, 1'b0, 1'b1);
    issue(64'h6003, 3'b111);
    chk("ill_req", {63'd0, mem_req}, 64'd0);
    chk("ill_done", {63'd0, done}, 64'd1);
    tick();

    // flush in IDLE
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_busy", {63'd0, busy}, 64'd0);

    // flush in REQ without ready withdraws the request
    issue(64'h7000, 3'b011);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("req_flush_req", {63'd0, mem_req}, 64'd0);
    chk("req_flush_busy", {63'd0, busy}, 64'd0);
    tick();

    // flush together with ready goes to DRAIN
    issue(64'h7008, 3'b011);
    mem_ready = 1'b1; flush = 1'b1;
    tick();
    mem_ready = 1'b0; flush = 1'b0;
    chk("req_hs_flush_busy", {63'd0, busy}, 64'd1);
    chk("req_hs_flush_req", {63'd0, mem_req}, 64'd0);
    respond(64'h55555555_55555555);
    chk("req_hs_drained", {63'd0, busy}, 64'd0);

    // flush with rvalid in WAIT discards data
    issue(64'h7010, 3'b011);
    handshake();
    flush = 1'b1;
    respond(64'h66666666_66666666);
    flush = 1'b0;
    chk("wait_flush_rv_busy", {63'd0, busy}, 64'd0);
    chk("wait_flush_rv_data", data, last_data);
    tick();

    // async reset mid-WAIT
    issue(64'h8000, 3'b011);
    handshake();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_req", {63'd0, mem_req}, 64'd0);
    chk("arst_mem_addr", mem_addr, 64'd0);
    chk("arst_data", data, 64'd0);
    chk("arst_offset", {61'd0, addr_offset}, 64'd0);
    chk("arst_func3", {61'd0, func_3_q}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_done", {63'd0, done}, 64'd0);
    end

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_mem_ctrl.md
Name: load_mem_ctrl

Overview:
- Sequential memory-access controller sitting directly upstream of the load data formatter in the MEM stage.
- Accepts a load request from the pipeline, pre-checks alignment, and issues a doubleword-aligned read over a valid/ready request channel.
- Waits for the read response, then registers the raw 64-bit doubleword together with the byte offset and func3 the formatter needs.
- Handles pipeline flush (including response drain) and response timeout.

Parameters:
- ADDR_WIDTH, 64, byte address width.
- DATA_WIDTH, 64, memory data width.
- TIMEOUT_CYCLES, 255, max cycles in WAIT before access fault; must be >= 1.

Ports:
- i_clk  input  1  clock, all flops rising edge.
- i_arstn  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle load request pulse; sampled only in IDLE.
- i_addr  input  ADDR_WIDTH  load byte address.
- i_func_3  input  3  load type (000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU).
- i_flush  input  1  kill in-flight load.
- o_mem_req  output  1  read request valid.
- o_mem_addr  output  ADDR_WIDTH  request address, {addr[ADDR_WIDTH-1:3], 3'b000}.
- i_mem_ready  input  1  request accepted when o_mem_req && i_mem_ready.
- i_mem_rvalid  input  1  read response valid.
- i_mem_rdata  input  DATA_WIDTH  read response data.
- o_data  output  DATA_WIDTH  registered raw doubleword for the formatter.
- o_addr_offset  output  3  registered i_addr[2:0].
- o_func_3  output  3  registered func3.
- o_done  output  1  one-cycle completion pulse.
- o_misaligned  output  1  valid with o_done; load was misaligned and no access was made.
- o_access_fault  output  1  valid with o_done; illegal func3 or timeout.
- o_busy  output  1  pipeline must stall.

Behaviour:
- Reset (async, i_arstn=0): state IDLE. All outputs 0, including o_data, o_addr_offset, o_func_3, o_done, o_misaligned, o_access_fault, o_mem_req and o_busy. Timeout counter 0.
- States: IDLE, REQ, WAIT, DRAIN, DONE. o_busy = state in {REQ, WAIT, DRAIN}. o_busy is low in DONE so the pipeline advances on the o_done cycle.
- On acceptance of i_start, register i_addr, i_func_3 and i_addr[2:0] into o_addr_offset and o_func_3.
- Misalignment check, decided on the i_start cycle:
  - LH/LHU: addr[0] != 0.
  - LW/LWU: addr[1:0] != 0.
  - LD: addr[2:0] != 0.
  - LB/LBU: never misaligned.
- IDLE:
  - i_start with func3=111 -> DONE, o_access_fault=1.
  - i_start with misaligned address -> DONE, o_misaligned=1.
  - Other i_start -> REQ.
  - i_flush in IDLE has no effect.
- REQ:
  - o_mem_req=1; o_mem_addr stable while in REQ.
  - i_mem_ready=1 -> WAIT and clear the counter; if i_flush is also 1 that cycle -> DRAIN instead.
  - i_flush=1 with i_mem_ready=0 -> IDLE; request withdrawn, memory side tolerates withdrawal.
- WAIT:
  - The response is never accepted in the same cycle as the request handshake; earliest response is the cycle after.
  - i_mem_rvalid=1 and no flush -> capture i_mem_rdata into o_data, go to DONE.
  - i_mem_rvalid=1 with i_flush=1 -> discard data, go to IDLE.
  - i_flush=1 without rvalid -> DRAIN.
  - Counter increments each WAIT cycle. When counter == TIMEOUT_CYCLES-1 and no rvalid -> DONE with o_access_fault=1.
  - A late response after a timeout is ignored in IDLE. Memory guarantees at most one outstanding response.
- DRAIN: o_done stays 0. i_mem_rvalid=1 -> IDLE, data discarded. i_flush is ignored.
- DONE:
  - o_done=1 for exactly one cycle; o_misaligned and o_access_fault are valid alongside it.
  - Next state is always IDLE.
  - i_start is ignored; upstream does not pulse it while o_busy=1 or in DONE.
  - o_misaligned and o_access_fault clear on exit from DONE.
- o_data, o_addr_offset and o_func_3 hold until the next capture. o_data is updated only on a successful response.
- Minimum latency, aligned load with ready and response in consecutive cycles: i_start (cycle 0) -> REQ (1, handshake) -> WAIT (2, rvalid) -> DONE (3).

Test Plan:
- Reset mid-WAIT: assert i_arstn=0 -> state IDLE immediately, all outputs 0, no o_done after release.
- LD at addr 0x1000, ready immediate, rvalid one cycle later with 0xDEADBEEF_CAFEF00D:
  - o_mem_addr=0x1000.
  - o_done at cycle 3, o_data=0xDEADBEEF_CAFEF00D, o_addr_offset=0, o_func_3=011.
- LW at 0x2006 -> no o_mem_req, o_done next cycle with o_misaligned=1.
- LB at 0x2007 with ready stalled 3 cycles and rvalid 5 cycles later:
  - o_mem_addr=0x2000 held during REQ.
  - o_busy high throughout.
  - o_addr_offset=7 on done.
- i_flush in WAIT, rvalid 4 cycles later -> DRAIN, no o_done; prior o_data unchanged; next i_start serviced normally.
- TIMEOUT_CYCLES=8, no rvalid -> o_done with o_access_fault=1 after 8 WAIT cycles; func3=111 -> immediate access fault, no request.
